// File: rtl/inst_fetch_ctrl_if.sv
// Bundle of control, decode handshake and instruction-RAM signals around the fetch controller.
// The master modport is the fetch controller's view; slave is the CPU/RAM side.
interface inst_fetch_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              start;
    logic              halt;
    logic              load_en;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [31:0]       inst_pc;
    logic              running;
    logic              halted;
    logic              im_cen;
    logic              im_wen;
    logic              im_oen;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_datain;
    logic [DATA_W-1:0] im_dataout;

    modport master (
        input  start, halt, load_en, load_valid, load_addr, load_data,
        input  redirect_valid, redirect_pc, inst_ready, im_dataout,
        output inst_valid, inst, inst_pc, running, halted,
        output im_cen, im_wen, im_oen, im_addr, im_datain
    );

    modport slave (
        output start, halt, load_en, load_valid, load_addr, load_data,
        output redirect_valid, redirect_pc, inst_ready, im_dataout,
        input  inst_valid, inst, inst_pc, running, halted,
        input  im_cen, im_wen, im_oen, im_addr, im_datain
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer for a 1-cycle synchronous instruction RAM: owns the PC,
// issues one read per cycle, buffers returns in an output register plus a 1-entry skid.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 11,
    parameter int          DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_ctrl_if.master   fetch
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        HALT
    } state_t;

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        pc_d;
    logic               req_q;
    logic [31:0]        reqPc_q;
    logic               outValid_q;
    logic [DATA_W-1:0]  out_q;
    logic [31:0]        outPc_q;
    logic               skidValid_q;
    logic [DATA_W-1:0]  skid_q;
    logic [31:0]        skidPc_q;
    logic               running_q;
    logic               halted_q;

    logic               inRun;
    logic               issue;
    logic               ramWrite;
    logic               transfer;
    logic               flush;

    // A read is only issued when its return is guaranteed a home: the skid is empty and
    // the output register is either empty or being drained this cycle.
    always_comb begin
        inRun    = (state_q == RUN);
        issue    = inRun && !fetch.redirect_valid && !fetch.halt && !skidValid_q
                   && (!outValid_q || fetch.inst_ready);
        ramWrite = (state_q == LOAD) && fetch.load_valid;
        transfer = outValid_q && fetch.inst_ready;
        flush    = (inRun && fetch.redirect_valid) || ((state_q == HALT) && fetch.start);

        pc_d = pc_q;
        if (((state_q == IDLE) && !fetch.load_en && fetch.start) ||
            ((state_q == HALT) && fetch.start)) begin
            pc_d = RESET_PC;
        end else if (inRun && fetch.redirect_valid) begin
            pc_d = fetch.redirect_pc & ~32'h0000_0003;
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
    end

    assign fetch.im_cen     = !(issue || ramWrite);
    assign fetch.im_wen     = !ramWrite;
    assign fetch.im_oen     = 1'b0;
    assign fetch.im_addr    = ramWrite ? fetch.load_addr : pc_q[ADDR_W+1:2];
    assign fetch.im_datain  = (state_q == LOAD) ? fetch.load_data : '0;

    assign fetch.inst_valid = outValid_q;
    assign fetch.inst       = out_q;
    assign fetch.inst_pc    = outPc_q;
    assign fetch.running    = running_q;
    assign fetch.halted     = halted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            reqPc_q     <= 32'h0;
            outValid_q  <= 1'b0;
            out_q       <= '0;
            outPc_q     <= 32'h0;
            skidValid_q <= 1'b0;
            skid_q      <= '0;
            skidPc_q    <= 32'h0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q <= pc_d;

            case (state_q)
                IDLE: begin
                    if (fetch.load_en) begin
                        state_q <= LOAD;
                    end else if (fetch.start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!fetch.load_en) begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (fetch.halt) begin
                        state_q   <= HALT;
                        running_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end
                end
                HALT: begin
                    if (fetch.start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        halted_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase

            req_q <= issue;
            if (issue) begin
                reqPc_q <= pc_q;
            end

            // Skid and an in-flight read never coexist, since a read is only issued with an empty skid.
            if (flush) begin
                req_q       <= 1'b0;
                outValid_q  <= 1'b0;
                skidValid_q <= 1'b0;
            end else if (transfer) begin
                if (skidValid_q) begin
                    out_q       <= skid_q;
                    outPc_q     <= skidPc_q;
                    skidValid_q <= 1'b0;
                end else if (req_q) begin
                    out_q   <= fetch.im_dataout;
                    outPc_q <= reqPc_q;
                end else begin
                    outValid_q <= 1'b0;
                end
            end else if (req_q) begin
                if (!outValid_q) begin
                    out_q      <= fetch.im_dataout;
                    outPc_q    <= reqPc_q;
                    outValid_q <= 1'b1;
                end else begin
                    skid_q      <= fetch.im_dataout;
                    skidPc_q    <= reqPc_q;
                    skidValid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a behavioural 2Kx32 synchronous-read RAM.
module tb_inst_fetch_ctrl;

    typedef struct {
        string       name;
        logic        st;
        logic        ld;
        logic        lv;
        logic [10:0] la;
        logic [31:0] ldat;
        logic        rdy;
        logic        eValid;
        logic [31:0] eInst;
        logic [31:0] ePc;
        logic        eRun;
        logic        eCen;
        logic        eWen;
        logic [10:0] eAddr;
    } vec_t;

    logic        clk;
    logic        rst;
    int          errors;
    int          checks;
    logic [31:0] mem [0:2047];
    logic [31:0] ramDout;
    vec_t        vecs [0:20];

    inst_fetch_ctrl_if #(.ADDR_W(11), .DATA_W(32)) fetchIf ();

    inst_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (11),
        .DATA_W   (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (fetchIf.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fetchIf.im_dataout = ramDout;

    always @(posedge clk) begin
        if (!fetchIf.im_cen) begin
            if (!fetchIf.im_wen) begin
                mem[fetchIf.im_addr] <= fetchIf.im_datain;
            end else begin
                ramDout <= mem[fetchIf.im_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        fetchIf.start          = 1'b0;
        fetchIf.halt           = 1'b0;
        fetchIf.load_en        = 1'b0;
        fetchIf.load_valid     = 1'b0;
        fetchIf.load_addr      = '0;
        fetchIf.load_data      = '0;
        fetchIf.redirect_valid = 1'b0;
        fetchIf.redirect_pc    = '0;
        fetchIf.inst_ready     = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        idleInputs();
        fetchIf.start      = v.st;
        fetchIf.load_en    = v.ld;
        fetchIf.load_valid = v.lv;
        fetchIf.load_addr  = v.la;
        fetchIf.load_data  = v.ldat;
        fetchIf.inst_ready = v.rdy;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".valid"}, {31'b0, fetchIf.inst_valid}, 32'h0);
        checkOutput({tag, ".inst"}, fetchIf.inst, 32'h0);
        checkOutput({tag, ".pc"}, fetchIf.inst_pc, 32'h0);
        checkOutput({tag, ".running"}, {31'b0, fetchIf.running}, 32'h0);
        checkOutput({tag, ".halted"}, {31'b0, fetchIf.halted}, 32'h0);
        checkOutput({tag, ".cen"}, {31'b0, fetchIf.im_cen}, 32'h1);
        checkOutput({tag, ".wen"}, {31'b0, fetchIf.im_wen}, 32'h1);
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Leaves the DUT in its first RUN cycle with inputs idle.
    task automatic startRun();
        idleInputs();
        fetchIf.start = 1'b1;
        tick();
        fetchIf.start = 1'b0;
    endtask

    initial begin
        int got;
        errors = 0;
        checks = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 | i;
        ramDout = '0;
        idleInputs();
        rst = 1'b1;
        #2;
        checkResetOutputs("reset");
        tick();
        rst = 1'b0;

        // Load words 0..7, return to IDLE, start and stream with ready held high.
        for (int i = 0; i <= 20; i++) begin
            vecs[i] = '{name: $sformatf("vec%0d", i), st: 1'b0, ld: 1'b0, lv: 1'b0, la: '0,
                        ldat: '0, rdy: 1'b0, eValid: 1'b0, eInst: '0, ePc: '0, eRun: 1'b0,
                        eCen: 1'b1, eWen: 1'b1, eAddr: '0};
        end
        vecs[0].ld = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vecs[i].ld    = 1'b1;
            vecs[i].lv    = 1'b1;
            vecs[i].la    = 11'(i - 1);
            vecs[i].ldat  = 32'h1000_0000 + 32'(i - 1);
            vecs[i].eCen  = 1'b0;
            vecs[i].eWen  = 1'b0;
            vecs[i].eAddr = 11'(i - 1);
        end
        vecs[10].st  = 1'b1;
        vecs[10].rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            vecs[11 + k].rdy   = 1'b1;
            vecs[11 + k].eRun  = 1'b1;
            vecs[11 + k].eCen  = 1'b0;
            vecs[11 + k].eAddr = 11'(k);
            if (k >= 2) begin
                vecs[11 + k].eValid = 1'b1;
                vecs[11 + k].eInst  = 32'h1000_0000 + 32'(k - 2);
                vecs[11 + k].ePc    = 32'(4 * (k - 2));
            end
        end

        for (int i = 0; i <= 20; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, ".valid"}, {31'b0, fetchIf.inst_valid}, {31'b0, vecs[i].eValid});
            checkOutput({vecs[i].name, ".running"}, {31'b0, fetchIf.running}, {31'b0, vecs[i].eRun});
            checkOutput({vecs[i].name, ".cen"}, {31'b0, fetchIf.im_cen}, {31'b0, vecs[i].eCen});
            checkOutput({vecs[i].name, ".wen"}, {31'b0, fetchIf.im_wen}, {31'b0, vecs[i].eWen});
            if (!vecs[i].eCen) checkOutput({vecs[i].name, ".addr"}, {21'b0, fetchIf.im_addr}, {21'b0, vecs[i].eAddr});
            if (vecs[i].eValid) begin
                checkOutput({vecs[i].name, ".inst"}, fetchIf.inst, vecs[i].eInst);
                checkOutput({vecs[i].name, ".pc"}, fetchIf.inst_pc, vecs[i].ePc);
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of streaming.
        rst = 1'b1;
        #1;
        checkResetOutputs("rstRun");
        tick();
        rst = 1'b0;

        // Three-cycle stall: every word delivered once, in order, with no reads while stalled.
        startRun();
        got = 0;
        for (int cyc = 1; cyc <= 40 && got < 8; cyc++) begin
            fetchIf.inst_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (cyc >= 4 && cyc <= 6) checkOutput($sformatf("stallNoIssue%0d", cyc), {31'b0, fetchIf.im_cen}, 32'h1);
            if (fetchIf.inst_valid && fetchIf.inst_ready) begin
                checkOutput($sformatf("skidInst%0d", got), fetchIf.inst, 32'h1000_0000 + 32'(got));
                checkOutput($sformatf("skidPc%0d", got), fetchIf.inst_pc, 32'(4 * got));
                got++;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("skidCount", 32'(got), 32'd8);
        doReset();

        // Redirect with one read in flight.
        startRun();
        fetchIf.inst_ready = 1'b1;
        #1;
        checkOutput("redirPreAddr", {21'b0, fetchIf.im_addr}, 32'h0);
        tick();
        fetchIf.redirect_valid = 1'b1;
        fetchIf.redirect_pc    = 32'h0000_0013;
        #1;
        checkOutput("redirNoIssue", {31'b0, fetchIf.im_cen}, 32'h1);
        tick();
        fetchIf.redirect_valid = 1'b0;
        #1;
        checkOutput("redirFlushValid", {31'b0, fetchIf.inst_valid}, 32'h0);
        checkOutput("redirAddr", {21'b0, fetchIf.im_addr}, 32'h4);
        checkOutput("redirCen", {31'b0, fetchIf.im_cen}, 32'h0);
        tick();
        checkOutput("redirValidLate", {31'b0, fetchIf.inst_valid}, 32'h0);
        tick();
        checkOutput("redirValid", {31'b0, fetchIf.inst_valid}, 32'h1);
        checkOutput("redirInst", fetchIf.inst, 32'h1000_0004);
        checkOutput("redirPc", fetchIf.inst_pc, 32'h10);
        doReset();

        // Halt while the output is held, then drain and restart.
        startRun();
        tick();
        tick();
        fetchIf.halt = 1'b1;
        #1;
        checkOutput("haltHeldInst", fetchIf.inst, 32'h1000_0000);
        tick();
        fetchIf.halt       = 1'b0;
        fetchIf.inst_ready = 1'b1;
        #1;
        checkOutput("haltHalted", {31'b0, fetchIf.halted}, 32'h1);
        checkOutput("haltRunning", {31'b0, fetchIf.running}, 32'h0);
        checkOutput("haltNoIssue0", {31'b0, fetchIf.im_cen}, 32'h1);
        checkOutput("haltDeliver0", fetchIf.inst_pc, 32'h0);
        tick();
        checkOutput("haltDeliver1Valid", {31'b0, fetchIf.inst_valid}, 32'h1);
        checkOutput("haltDeliver1", fetchIf.inst, 32'h1000_0001);
        checkOutput("haltNoIssue1", {31'b0, fetchIf.im_cen}, 32'h1);
        tick();
        checkOutput("haltDrained", {31'b0, fetchIf.inst_valid}, 32'h0);
        checkOutput("haltNoIssue2", {31'b0, fetchIf.im_cen}, 32'h1);
        fetchIf.start = 1'b1;
        tick();
        fetchIf.start = 1'b0;
        #1;
        checkOutput("restartRunning", {31'b0, fetchIf.running}, 32'h1);
        checkOutput("restartHalted", {31'b0, fetchIf.halted}, 32'h0);
        checkOutput("restartCen", {31'b0, fetchIf.im_cen}, 32'h0);
        checkOutput("restartAddr", {21'b0, fetchIf.im_addr}, 32'h0);
        doReset();

        // Address wrap from the last RAM word back to word 0.
        fetchIf.load_en = 1'b1;
        tick();
        fetchIf.load_valid = 1'b1;
        fetchIf.load_addr  = 11'd2047;
        fetchIf.load_data  = 32'hCAFE_07FF;
        tick();
        idleInputs();
        tick();
        startRun();
        fetchIf.inst_ready     = 1'b1;
        fetchIf.redirect_valid = 1'b1;
        fetchIf.redirect_pc    = 32'h0000_1FFC;
        tick();
        fetchIf.redirect_valid = 1'b0;
        #1;
        checkOutput("wrapAddrTop", {21'b0, fetchIf.im_addr}, 32'd2047);
        tick();
        checkOutput("wrapAddrZero", {21'b0, fetchIf.im_addr}, 32'd0);
        checkOutput("wrapCen", {31'b0, fetchIf.im_cen}, 32'h0);
        tick();
        checkOutput("wrapInstTop", fetchIf.inst, 32'hCAFE_07FF);
        checkOutput("wrapPcTop", fetchIf.inst_pc, 32'h1FFC);
        tick();
        checkOutput("wrapInstZero", fetchIf.inst, 32'h1000_0000);
        checkOutput("wrapPcZero", fetchIf.inst_pc, 32'h2000);
        doReset();

        // Asynchronous reset during a load write, then a clean restart from the reset PC.
        fetchIf.load_en = 1'b1;
        tick();
        fetchIf.load_valid = 1'b1;
        fetchIf.load_addr  = 11'd9;
        fetchIf.load_data  = 32'h5555_AAAA;
        #1;
        checkOutput("loadWen", {31'b0, fetchIf.im_wen}, 32'h0);
        rst = 1'b1;
        #1;
        checkResetOutputs("rstLoad");
        tick();
        idleInputs();
        rst = 1'b0;
        startRun();
        fetchIf.inst_ready = 1'b1;
        tick();
        tick();
        checkOutput("rerunValid", {31'b0, fetchIf.inst_valid}, 32'h1);
        checkOutput("rerunInst", fetchIf.inst, 32'h1000_0000);
        checkOutput("rerunPc", fetchIf.inst_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
